input_decoder_cmd_ctrl: RTL and testbench

INPUT_DECODER_CMD_CTRL -- requirements
Module: input_decoder_cmd_ctrl

---
 rtl/input_decoder_cmd_ctrl.sv | 139 +++++++++++++
 tb/tb_input_decoder_cmd_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_decoder_cmd_ctrl.sv
// Command decoder: pops a header word plus up to MAX_PARAMS parameter words from
// a FIFO and presents the assembled command on a valid/ready handshake.
module input_decoder_cmd_ctrl #(
  parameter int unsigned MAX_PARAMS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       fifo_empty,
  input  logic [31:0]                fifo_r_data,
  output logic                       fifo_read,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [3:0]                 cmd_opcode,
  output logic [2:0]                 cmd_nparam,
  output logic [32*MAX_PARAMS-1:0]   cmd_params,
  output logic                       bad_cmd,
  output logic                       busy,
  output logic [15:0]                cmd_count
);

  localparam logic [2:0] MaxNp = 3'(MAX_PARAMS);

  typedef enum logic [2:0] {
    IDLE,
    HDR_WAIT,
    PRM_RD,
    PRM_WAIT,
    DRAIN_RD,
    DRAIN_WAIT,
    ISSUE
  } state_e;

  state_e                    state_q, state_d;
  logic [3:0]                opcode_q, opcode_d;
  logic [2:0]                nparam_q, nparam_d;
  logic [2:0]                idx_q, idx_d;
  logic [32*MAX_PARAMS-1:0]  params_q, params_d;
  logic                      bad_q, bad_d;
  logic [15:0]               count_q, count_d;
  logic [2:0]                hdr_np;
  logic                      unused_hdr_bits;

  assign hdr_np          = fifo_r_data[2:0];
  assign unused_hdr_bits = ^fifo_r_data[27:3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      nparam_q <= '0;
      idx_q    <= '0;
      params_q <= '0;
      bad_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      nparam_q <= nparam_d;
      idx_q    <= idx_d;
      params_q <= params_d;
      bad_q    <= bad_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    nparam_d  = nparam_q;
    idx_d     = idx_q;
    params_d  = params_q;
    bad_d     = 1'b0;
    count_d   = count_q;
    fifo_read = 1'b0;
    unique case (state_q)
      IDLE: begin
        // reset also masks the pop so nothing leaves the FIFO while held in reset
        if (en && !fifo_empty && !reset) begin
          fifo_read = 1'b1;
          state_d   = HDR_WAIT;
        end
      end
      HDR_WAIT: begin
        opcode_d = fifo_r_data[31:28];
        nparam_d = hdr_np;
        params_d = '0;
        idx_d    = '0;
        if (hdr_np == 3'd0) begin
          state_d = ISSUE;
        end else if (hdr_np <= MaxNp) begin
          state_d = PRM_RD;
        end else begin
          state_d = DRAIN_RD;
          bad_d   = 1'b1;
        end
      end
      PRM_RD: begin
        if (!fifo_empty) begin
          fifo_read = 1'b1;
          state_d   = PRM_WAIT;
        end
      end
      PRM_WAIT: begin
        for (int unsigned k = 0; k < MAX_PARAMS; k++) begin
          if (idx_q == 3'(k)) params_d[32*k +: 32] = fifo_r_data;
        end
        idx_d   = idx_q + 3'd1;
        state_d = ((idx_q + 3'd1) == nparam_q) ? ISSUE : PRM_RD;
      end
      DRAIN_RD: begin
        if (!fifo_empty) begin
          fifo_read = 1'b1;
          state_d   = DRAIN_WAIT;
        end
      end
      DRAIN_WAIT: begin
        idx_d   = idx_q + 3'd1;
        state_d = ((idx_q + 3'd1) == nparam_q) ? IDLE : DRAIN_RD;
      end
      ISSUE: begin
        if (cmd_ready) begin
          state_d = IDLE;
          count_d = count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_valid  = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);
  assign cmd_opcode = opcode_q;
  assign cmd_nparam = nparam_q;
  assign cmd_params = params_q;
  assign bad_cmd    = bad_q;
  assign cmd_count  = count_q;

endmodule

// File: tb/tb_input_decoder_cmd_ctrl.sv
// Directed and randomized bench for input_decoder_cmd_ctrl with a queue-based
// FIFO and a list-level command reference model.
module tb_input_decoder_cmd_ctrl;
  localparam int unsigned MAXP = 4;
  localparam int PW = 32 * MAXP;

  logic clk = 1'b0;
  logic reset, en, fifo_empty, fifo_read, cmd_valid, cmd_ready, bad_cmd, busy;
  logic [31:0] fifo_r_data;
  logic [3:0] cmd_opcode;
  logic [2:0] cmd_nparam;
  logic [PW-1:0] cmd_params;
  logic [15:0] cmd_count;

  int errors = 0;
  int checks = 0;
  int pops = 0;
  int pop_err = 0;
  logic stall = 1'b0;
  logic [31:0] fq[$];

  typedef struct {
    logic [3:0]    op;
    logic [2:0]    np;
    logic [PW-1:0] prm;
  } cmd_t;
  cmd_t exp_q[$];

  input_decoder_cmd_ctrl #(.MAX_PARAMS(MAXP)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_r_data(fifo_r_data),
    .fifo_read  (fifo_read),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_nparam (cmd_nparam),
    .cmd_params (cmd_params),
    .bad_cmd    (bad_cmd),
    .busy       (busy),
    .cmd_count  (cmd_count)
  );

  always #5 clk = ~clk;

  // Input FIFO: read data appears the cycle after the pop.
  always @(posedge clk) begin
    if (fifo_read) begin
      pops++;
      if (fq.size() == 0) pop_err++;
      else fifo_r_data <= fq.pop_front();
    end
    fifo_empty <= (fq.size() == 0) || stall;
  end

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    fifo_empty = stall;
  endtask

  task automatic wait_valid(input int budget, output int k);
    k = 0;
    while (!cmd_valid && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd"},    PW'(fifo_read),  '0);
    chk({tag, "_valid"}, PW'(cmd_valid),  '0);
    chk({tag, "_bad"},   PW'(bad_cmd),    '0);
    chk({tag, "_busy"},  PW'(busy),       '0);
    chk({tag, "_op"},    PW'(cmd_opcode), '0);
    chk({tag, "_np"},    PW'(cmd_nparam), '0);
    chk({tag, "_prm"},   cmd_params,      '0);
    chk({tag, "_cnt"},   PW'(cmd_count),  '0);
  endtask

  initial begin
    int k, base, bad_n, op1_n, bad_k, exp_bad, words, exp_cnt;
    logic seen2, held;
    logic [3:0] op, p_op;
    logic [2:0] np, p_np;
    logic [PW-1:0] prm, p_prm;
    logic [31:0] hdr, d;
    cmd_t e;

    reset = 1'b1; en = 1'b0; cmd_ready = 1'b0; fifo_r_data = '0; fifo_empty = 1'b1;
    repeat (2) tick();
    chk_zero("rst");
    reset = 1'b0;
    tick();
    chk("idle_busy", PW'(busy), '0);

    // Zero-parameter command
    en = 1'b1; cmd_ready = 1'b1;
    push(32'h3000_0000);
    #1;
    chk("t1_hdr_rd", PW'(fifo_read), PW'(1));
    wait_valid(20, k);
    chk("t1_lat", PW'(k), PW'(2));
    chk("t1_op", PW'(cmd_opcode), PW'(3));
    chk("t1_np", PW'(cmd_nparam), PW'(0));
    chk("t1_prm", cmd_params, '0);
    tick();
    chk("t1_cnt", PW'(cmd_count), PW'(1));
    chk("t1_valid_drop", PW'(cmd_valid), PW'(0));

    // Two parameters, then back-to-back header fetch
    push(32'h5000_0002); push(32'hAAAA_0001); push(32'hBBBB_0002); push(32'h7000_0000);
    #1;
    chk("t2_hdr_rd", PW'(fifo_read), PW'(1));
    wait_valid(30, k);
    chk("t2_lat", PW'(k), PW'(6));
    chk("t2_op", PW'(cmd_opcode), PW'(5));
    chk("t2_np", PW'(cmd_nparam), PW'(2));
    chk("t2_prm", cmd_params, {64'h0, 32'hBBBB_0002, 32'hAAAA_0001});
    tick();
    chk("t2_cnt", PW'(cmd_count), PW'(2));
    chk("t2_next_hdr_rd", PW'(fifo_read), PW'(1));
    wait_valid(20, k);
    chk("t2b_lat", PW'(k), PW'(2));
    chk("t2b_op", PW'(cmd_opcode), PW'(7));
    chk("t2b_prm", cmd_params, '0);
    tick();
    chk("t2b_cnt", PW'(cmd_count), PW'(3));

    // Oversized command is drained, then the following command issues
    base = pops;
    push(32'h1000_0006);
    for (int i = 1; i <= 6; i++) push(32'hD000_0000 + 32'(i));
    push(32'h2000_0000);
    #1;
    chk("t3_hdr_rd", PW'(fifo_read), PW'(1));
    bad_n = 0; op1_n = 0; bad_k = -1; seen2 = 1'b0;
    for (int c = 0; c < 40 && !seen2; c++) begin
      tick();
      if (bad_cmd) begin
        bad_n++;
        if (bad_k < 0) bad_k = c + 1;
      end
      if (cmd_valid && cmd_opcode == 4'h1) op1_n++;
      if (cmd_valid && cmd_opcode == 4'h2) begin
        seen2 = 1'b1;
        chk("t3_pops", PW'(pops - base), PW'(8));
        chk("t3_np2", PW'(cmd_nparam), PW'(0));
      end
    end
    chk("t3_seen2", PW'(seen2), PW'(1));
    chk("t3_bad_pulses", PW'(bad_n), PW'(1));
    chk("t3_bad_cycle", PW'(bad_k), PW'(2));
    chk("t3_no_op1", PW'(op1_n), PW'(0));
    tick();
    chk("t3_cnt", PW'(cmd_count), PW'(4));

    // FIFO runs dry after the first parameter
    push(32'h6000_0002); push(32'h1111_1111);
    #1;
    chk("t4_hdr_rd", PW'(fifo_read), PW'(1));
    repeat (3) tick();
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("t4_stall_rd", PW'(fifo_read), PW'(0));
      chk("t4_stall_busy", PW'(busy), PW'(1));
    end
    push(32'h2222_2222);
    #1;
    chk("t4_refill_rd", PW'(fifo_read), PW'(1));
    wait_valid(20, k);
    chk("t4_lat", PW'(k), PW'(2));
    chk("t4_op", PW'(cmd_opcode), PW'(6));
    chk("t4_prm", cmd_params, {64'h0, 32'h2222_2222, 32'h1111_1111});
    tick();
    chk("t4_cnt", PW'(cmd_count), PW'(5));

    // Backpressure in ISSUE
    cmd_ready = 1'b0;
    push(32'h9000_0001); push(32'hCAFE_F00D); push(32'h4000_0000);
    #1;
    chk("t5_hdr_rd", PW'(fifo_read), PW'(1));
    wait_valid(20, k);
    chk("t5_lat", PW'(k), PW'(4));
    for (int s = 0; s < 10; s++) begin
      chk("t5_hold_valid", PW'(cmd_valid), PW'(1));
      chk("t5_hold_op", PW'(cmd_opcode), PW'(9));
      chk("t5_hold_np", PW'(cmd_nparam), PW'(1));
      chk("t5_hold_prm", cmd_params, {96'h0, 32'hCAFE_F00D});
      chk("t5_hold_rd", PW'(fifo_read), PW'(0));
      chk("t5_hold_cnt", PW'(cmd_count), PW'(5));
      tick();
    end
    cmd_ready = 1'b1;
    tick();
    chk("t5_cnt", PW'(cmd_count), PW'(6));
    chk("t5_next_hdr_rd", PW'(fifo_read), PW'(1));
    wait_valid(20, k);
    chk("t5b_op", PW'(cmd_opcode), PW'(4));
    tick();
    chk("t5b_cnt", PW'(cmd_count), PW'(7));

    // Reset in PRM_WAIT, then counter wrap
    push(32'h8000_0003); push(32'h1111_0000); push(32'hB000_0001); push(32'h0000_00C0);
    #1;
    chk("t6_hdr_rd", PW'(fifo_read), PW'(1));
    repeat (3) tick();
    chk("t6_busy_pre", PW'(busy), PW'(1));
    chk("t6_op_pre", PW'(cmd_opcode), PW'(8));
    reset = 1'b1;
    #1;
    chk_zero("t6_rst");
    tick();
    chk_zero("t6_rst_hold");
    en = 1'b0; reset = 1'b0;
    tick();
    chk("t6_cnt0", PW'(cmd_count), PW'(0));
    force dut.count_q = 16'hFFFF;
    tick();
    release dut.count_q;
    tick();
    chk("t6_preset", PW'(cmd_count), PW'(16'hFFFF));
    en = 1'b1;
    #1;
    chk("t6_resume_rd", PW'(fifo_read), PW'(1));
    wait_valid(20, k);
    chk("t6_lat", PW'(k), PW'(4));
    chk("t6_op", PW'(cmd_opcode), PW'(4'hB));
    chk("t6_np", PW'(cmd_nparam), PW'(1));
    chk("t6_prm", cmd_params, {96'h0, 32'h0000_00C0});
    tick();
    chk("t6_wrap", PW'(cmd_count), PW'(0));

    // Randomized traffic against the list-level model
    base = pops; exp_bad = 0; words = 0; exp_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      np  = 3'($urandom_range(0, 7));
      op  = 4'($urandom_range(0, 15));
      hdr = {op, 25'($urandom), np};
      push(hdr);
      words++;
      prm = '0;
      for (int w = 0; w < int'(np); w++) begin
        d = $urandom;
        push(d);
        words++;
        if (np <= 3'(MAXP)) prm[32*w +: 32] = d;
      end
      if (np <= 3'(MAXP)) begin
        e.op = op; e.np = np; e.prm = prm;
        exp_q.push_back(e);
      end else begin
        exp_bad++;
      end
    end
    bad_n = 0; held = 1'b0; p_op = '0; p_np = '0; p_prm = '0;
    for (int c = 0; c < 20000; c++) begin
      if (exp_q.size() == 0 && fq.size() == 0 && !busy) break;
      if (bad_cmd) bad_n++;
      if (held) begin
        chk("r_hold_valid", PW'(cmd_valid), PW'(1));
        chk("r_hold_op", PW'(cmd_opcode), PW'(p_op));
        chk("r_hold_np", PW'(cmd_nparam), PW'(p_np));
        chk("r_hold_prm", cmd_params, p_prm);
      end
      if (cmd_valid) chk("r_no_rd_in_issue", PW'(fifo_read), PW'(0));
      cmd_ready  = ($urandom_range(0, 9) < 6);
      en         = ($urandom_range(0, 3) != 0);
      stall      = ($urandom_range(0, 3) == 0);
      fifo_empty = (fq.size() == 0) || stall;
      held = 1'b0;
      if (cmd_valid) begin
        if (cmd_ready) begin
          chk("r_expected_cmd", PW'(exp_q.size() != 0), PW'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("r_op", PW'(cmd_opcode), PW'(e.op));
            chk("r_np", PW'(cmd_nparam), PW'(e.np));
            chk("r_prm", cmd_params, e.prm);
            exp_cnt++;
          end
        end else begin
          held = 1'b1;
          p_op = cmd_opcode; p_np = cmd_nparam; p_prm = cmd_params;
        end
      end
      tick();
    end
    stall = 1'b0;
    fifo_empty = (fq.size() == 0);
    chk("r_all_issued", PW'(exp_q.size()), PW'(0));
    chk("r_bad_pulses", PW'(bad_n), PW'(exp_bad));
    chk("r_pops", PW'(pops - base), PW'(words));
    chk("r_cnt", PW'(cmd_count), PW'(16'(exp_cnt)));
    chk("r_no_underflow", PW'(pop_err), PW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
